// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared OP encodings and FSM state type for the execute ALU
package alu_pkg;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_LSL  = 4'b0011;
   localparam logic [3:0] OP_LSR  = 4'b0100;
   localparam logic [3:0] OP_ASR  = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_PASS = 4'b0111;
   localparam logic [3:0] OP_MUL  = 4'b1000;
   localparam logic [3:0] OP_NOR  = 4'b1100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - iterative shift-add multiplier, MUL_STEP multiplier bits per cycle
module alu_mul_iter #(
   parameter int WIDTH    = 64,
   parameter int MUL_STEP = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   localparam int STEPS = WIDTH / MUL_STEP;
   localparam int CW    = $clog2(STEPS + 1);

   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] partial;

   // Partial product of this cycle's MUL_STEP multiplier bits against the shifted multiplicand
   always_comb begin
      partial = '0;
      for (int i = 0; i < MUL_STEP; i++) begin
         if (mplier[i]) begin
            partial = partial + (mcand << i);
         end
      end
   end

   // Product includes the current step, so the caller can register it on the final step's edge
   assign product = acc + partial;
   assign done    = (cnt == CW'(1));

   // Load operands on start, then retire MUL_STEP bits per cycle until the counter drains
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
      end else if (start) begin
         acc    <= '0;
         mcand  <= a;
         mplier <= b;
         cnt    <= CW'(STEPS);
      end else if (cnt != '0) begin
         acc    <= product;
         mcand  <= mcand << MUL_STEP;
         mplier <= mplier >> MUL_STEP;
         cnt    <= cnt - CW'(1);
      end
   end

endmodule

// File: rtl/alu_pipe_mc.sv
// rtl/alu_pipe_mc.sv - multi-cycle execute ALU with valid/ready handshake and NZCV flags
module alu_pipe_mc
   import alu_pkg::*;
#(
   parameter int WIDTH    = 64,
   parameter int MUL_STEP = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] input1,
   input  logic [WIDTH-1:0] input2,
   input  logic [3:0]       OP,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ALUOutput,
   output logic             zero,
   output logic             negative,
   output logic             carry,
   output logic             overflow,
   output logic             op_err
);

   localparam int SHW = $clog2(WIDTH);

   state_t state;
   state_t state_nxt;

   logic             accept;
   logic             is_mul;
   logic             mul_start;
   logic             mul_done;
   logic [WIDTH-1:0] mul_product;

   logic [WIDTH:0]   sum_ext;
   logic [SHW-1:0]   sh;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c;
   logic             alu_v;
   logic             alu_err;

   assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
   assign out_valid = (state == DONE);
   assign accept    = in_valid && in_ready;
   assign is_mul    = (OP == OP_MUL);
   assign sum_ext   = {1'b0, input1} + {1'b0, input2};
   assign sh        = input2[SHW-1:0];

   // Single-cycle operations and their carry/overflow, evaluated from the live operands
   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      alu_err = 1'b0;
      case (OP)
         OP_AND:  alu_res = input1 & input2;
         OP_OR:   alu_res = input1 | input2;
         OP_NOR:  alu_res = ~(input1 | input2);
         OP_PASS: alu_res = input1;
         OP_LSL:  alu_res = input1 << sh;
         OP_LSR:  alu_res = input1 >> sh;
         OP_ASR:  alu_res = WIDTH'($signed(input1) >>> sh);
         OP_ADD: begin
            alu_res = sum_ext[WIDTH-1:0];
            alu_c   = sum_ext[WIDTH];
            alu_v   = (input1[WIDTH-1] == input2[WIDTH-1]) &&
                      (alu_res[WIDTH-1] != input1[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = input1 - input2;
            alu_c   = (input1 >= input2);
            alu_v   = (input1[WIDTH-1] != input2[WIDTH-1]) &&
                      (alu_res[WIDTH-1] != input1[WIDTH-1]);
         end
         OP_MUL:  alu_res = '0;
         default: alu_err = 1'b1;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and multiplier launch; DONE can accept the next op in the retire cycle
   always_comb begin
      state_nxt = state;
      mul_start = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               mul_start = is_mul;
               state_nxt = is_mul ? BUSY : DONE;
            end
         end
         BUSY: begin
            if (mul_done) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (accept) begin
               mul_start = is_mul;
               state_nxt = is_mul ? BUSY : DONE;
            end else if (out_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Result/flag registers: loaded at a non-MUL accept or on the multiplier's last step, else held
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ALUOutput <= '0;
         zero      <= 1'b0;
         negative  <= 1'b0;
         carry     <= 1'b0;
         overflow  <= 1'b0;
         op_err    <= 1'b0;
      end else if (accept && !is_mul) begin
         ALUOutput <= alu_res;
         zero      <= (alu_res == '0);
         negative  <= alu_res[WIDTH-1];
         carry     <= alu_c;
         overflow  <= alu_v;
         op_err    <= alu_err;
      end else if ((state == BUSY) && mul_done) begin
         ALUOutput <= mul_product;
         zero      <= (mul_product == '0);
         negative  <= mul_product[WIDTH-1];
         carry     <= 1'b0;
         overflow  <= 1'b0;
         op_err    <= 1'b0;
      end
   end

   alu_mul_iter #(
      .WIDTH    (WIDTH),
      .MUL_STEP (MUL_STEP)
   ) u_mul (
      .clk     (clk),
      .reset   (reset),
      .start   (mul_start),
      .a       (input1),
      .b       (input2),
      .done    (mul_done),
      .product (mul_product)
   );

endmodule
